encoder8x3_scan: RTL and testbench
==================================

Name: encoder8x3_scan

Overview:
- Sequential inverse of the 3-to-8 decoder.
- Accepts an 8-bit vector and emits the 3-bit index of every set bit, lowest index first, one index per output handshake.
- Re-decoding each emitted index with the 3-to-8 decoder and OR-ing the results reconstructs the accepted vector.
- Sits between request/flag producers and any index-consuming logic (arbiters, register selects).

Parameters:
- N, 8: input vector width; must equal 2**W.
- W, 3: output index width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- d  input  N  vector to encode, sampled on accept
- in_valid  input  1  d is valid
- in_ready  output  1  block can accept d
- i  output  W  index of the current set bit
- out_valid  output  1  i is valid
- out_ready  input  1  consumer takes i
- last  output  1  i is the highest set bit of the accepted vector
- zero  output  1  one-cycle pulse: an all-zero vector was accepted

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - State goes to IDLE; internal pending vector p clears.
  - Registered outputs clear: out_valid=0, i=0, last=0, zero=0.
  - in_ready=0 while reset is high, then 1 in IDLE.
- in_ready is combinational: 1 iff state==IDLE and reset==0.
- Accept = in_valid & in_ready at a rising edge.
- States:
  - IDLE:
    - On accept with d!=0: p<=d; i<=index of lowest set bit of d; last<=(d has exactly one set bit); out_valid<=1; go SCAN.
    - On accept with d==0: stay IDLE; zero<=1 for exactly one cycle; no out_valid.
  - SCAN:
    - in_ready=0; in_valid is ignored and nothing is sampled.
    - out_valid=1; i and last are held stable until out_ready=1.
    - Output handshake with last=0: clear bit i in p; on the same edge load i/last for the next-lowest set bit. Back-to-back: one index per cycle when out_ready is held high.
    - Output handshake with last=1: p<=0; out_valid<=0; last<=0; go IDLE; in_ready=1 the following cycle. No same-cycle re-accept.
- Latency:
  - First index valid the cycle after accept.
  - A vector with k set bits with out_ready constantly high: k cycles in SCAN, plus 1 cycle back in IDLE before the next accept.
- Index arithmetic: i = position of the least-significant set bit of p, 0..N-1; bit 0 maps to i=0. last = (p & (p-1))==0 for the current p.
- Boundaries:
  - d=8'h80 gives i=7, last=1 in a single transfer.
  - d=8'hFF gives 8 transfers: 0..7.
  - No wrap-around; indices are strictly increasing within a vector.
- Reset mid-SCAN: pending bits are discarded, out_valid drops the next edge, and no further indices are emitted.
- out_ready while out_valid=0: ignored.

Test Plan:
- d=8'h01, in_valid pulse, out_ready=1 -> next cycle out_valid=1, i=0, last=1; following cycle out_valid=0, in_ready=1.
- d=8'hA5, out_ready=1 -> consecutive cycles i=0,2,5,7; last=1 only on i=7; 4 cycles in SCAN.
- d=8'hFF, out_ready toggled 1,0,1,0... -> i=0..7 each held across stalls; exactly 8 transfers; in_valid pulsed during SCAN with d=8'h0F is not accepted.
- d=8'h00 -> zero=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
- d=8'hF0, reset asserted after the i=5 transfer -> out_valid=0 next cycle, no i=6/7, then clean accept of d=8'h02 yields i=1, last=1.
- Exhaustive: all 256 d values, with the counter pattern driving d -> OR of decoded i over each vector equals d; transfer count equals popcount(d); zero pulses only for d=0.

Source files
------------

// File: rtl/encoder8x3_scan.sv
// Sequential 8-to-3 encoder: accepts a vector and emits the index of every set
// bit, lowest first, one index per output handshake.
module encoder8x3_scan #(
  parameter int N = 8,  // vector width, must equal 2**W
  parameter int W = 3   // index width
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         last,
  output logic         zero
);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t       r_state;
  logic [N-1:0] r_p;
  logic [W-1:0] r_i;
  logic         r_last;
  logic         r_out_valid;
  logic         r_zero;

  logic         w_accept;
  logic         w_out_xfer;
  logic [N-1:0] w_p_next;

  // Position of the least-significant set bit; 0 for an all-zero vector.
  function automatic logic [W-1:0] lsb_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (v[k]) idx = W'(k);
    end
    return idx;
  endfunction

  function automatic logic at_most_one_bit(input logic [N-1:0] v);
    return (v & (v - N'(1))) == '0;
  endfunction

  assign in_ready   = (r_state == S_IDLE) && !reset;
  assign w_accept   = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  // Clearing the lowest set bit of p drops exactly the index being emitted.
  assign w_p_next   = r_p & (r_p - N'(1));

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_p         <= '0;
      r_i         <= '0;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_zero <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (d != '0) begin
              r_p         <= d;
              r_i         <= lsb_index(d);
              r_last      <= at_most_one_bit(d);
              r_out_valid <= 1'b1;
              r_state     <= S_SCAN;
            end else begin
              r_zero <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (w_out_xfer) begin
            if (r_last) begin
              r_p         <= '0;
              r_last      <= 1'b0;
              r_out_valid <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_p    <= w_p_next;
              r_i    <= lsb_index(w_p_next);
              r_last <= at_most_one_bit(w_p_next);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i         = r_i;
  assign last      = r_last;
  assign out_valid = r_out_valid;
  assign zero      = r_zero;

endmodule

// File: tb/tb_encoder8x3_scan.sv
// Scoreboard bench for encoder8x3_scan: stimulus pushes expected indices, a
// negedge monitor pops and compares on every output handshake or zero pulse.
module tb_encoder8x3_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] i;
  logic       out_valid;
  logic       out_ready;
  logic       last;
  logic       zero;

  typedef struct packed {
    logic       is_zero;
    logic [2:0] idx;
    logic       last;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    xfer_count = 0;
  int    acc_cnt  = 0;
  int    acc_zero = 0;
  logic [7:0] acc_or = '0;

  encoder8x3_scan #(.N(8), .W(3)) dut (
    .clk(clk), .reset(reset), .d(d), .in_valid(in_valid), .in_ready(in_ready),
    .i(i), .out_valid(out_valid), .out_ready(out_ready), .last(last), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic item_t mk(input logic z, input int idx, input logic l);
    item_t it;
    it.is_zero = z;
    it.idx     = 3'(idx);
    it.last    = l;
    return it;
  endfunction

  // Monitor: samples midway between rising edges, where a handshake seen here
  // is the one the next rising edge commits.
  always @(negedge clk) begin
    item_t exp;
    if (!reset && zero) begin
      acc_zero++;
      if (sb.size() == 0) check("unexpected_zero", 1, 0);
      else begin
        exp = sb.pop_front();
        check("zero_expected", 32'(exp.is_zero), 1);
      end
    end
    if (!reset && out_valid && out_ready) begin
      xfer_count++;
      acc_cnt++;
      acc_or = acc_or | (8'h01 << i);
      if (sb.size() == 0) check("unexpected_xfer", 32'(i), 32'hFFFF);
      else begin
        exp = sb.pop_front();
        check("xfer_kind", 32'(exp.is_zero), 0);
        check("xfer_i", 32'(i), 32'(exp.idx));
        check("xfer_last", 32'(last), 32'(exp.last));
      end
    end else if (!reset && out_valid && !out_ready && sb.size() != 0) begin
      check("stall_hold_i", 32'(i), 32'(sb[0].idx));
      check("stall_hold_last", 32'(last), 32'(sb[0].last));
    end
  end

  task automatic send(input logic [7:0] v);
    @(posedge clk); #1;
    d        = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt;
    for (cnt = 0; cnt < 200; cnt++) begin
      if (in_ready && sb.size() == 0) break;
      @(posedge clk); #1;
    end
    if (cnt >= 200) check("wait_idle_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cnt;
    reset     = 1'b1;
    d         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_i", 32'(i), 0);
    check("rst_last", 32'(last), 0);
    check("rst_zero", 32'(zero), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 1);

    // Single bit 0
    sb.push_back(mk(0, 0, 1));
    send(8'h01);
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_i", 32'(i), 0);
    check("t1_last", 32'(last), 1);
    @(posedge clk); #1;
    check("t1_out_valid_drop", 32'(out_valid), 0);
    check("t1_in_ready", 32'(in_ready), 1);
    wait_idle();

    // 0xA5 back-to-back: 0,2,5,7 and exactly 4 cycles in SCAN
    sb.push_back(mk(0, 0, 0));
    sb.push_back(mk(0, 2, 0));
    sb.push_back(mk(0, 5, 0));
    sb.push_back(mk(0, 7, 1));
    base = xfer_count;
    send(8'hA5);
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("a5_scan_cycles", 32'(cnt), 4);
    check("a5_xfers", 32'(xfer_count - base), 4);
    wait_idle();

    // 0xFF with out_ready toggling; 0x0F offered mid-scan must be ignored
    sb.push_back(mk(0, 0, 0));
    sb.push_back(mk(0, 1, 0));
    sb.push_back(mk(0, 2, 0));
    sb.push_back(mk(0, 3, 0));
    sb.push_back(mk(0, 4, 0));
    sb.push_back(mk(0, 5, 0));
    sb.push_back(mk(0, 6, 0));
    sb.push_back(mk(0, 7, 1));
    base = xfer_count;
    send(8'hFF);
    for (int c = 0; c < 20; c++) begin
      out_ready = (c % 2 == 0);
      if (c == 3) begin
        d        = 8'h0F;
        in_valid = 1'b1;
        check("ff_in_ready_scan", 32'(in_ready), 0);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    check("ff_xfers", 32'(xfer_count - base), 8);

    // All-zero vector: one-cycle zero pulse, no output
    sb.push_back(mk(1, 0, 0));
    send(8'h00);
    check("z_zero_hi", 32'(zero), 1);
    check("z_out_valid", 32'(out_valid), 0);
    check("z_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    check("z_zero_lo", 32'(zero), 0);
    check("z_out_valid2", 32'(out_valid), 0);
    wait_idle();

    // Reset after the i=5 transfer of 0xF0
    sb.push_back(mk(0, 4, 0));
    sb.push_back(mk(0, 5, 0));
    send(8'hF0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("f0_i6_presented", 32'(i), 6);
    reset = 1'b1;
    @(posedge clk); #1;
    check("f0_rst_out_valid", 32'(out_valid), 0);
    check("f0_rst_in_ready", 32'(in_ready), 0);
    check("f0_sb_drained", 32'(sb.size()), 0);
    reset = 1'b0;
    #1;
    check("f0_in_ready_after", 32'(in_ready), 1);
    sb.push_back(mk(0, 1, 1));
    send(8'h02);
    wait_idle();

    // Exhaustive: reconstruct each vector from its emitted indices
    for (int v = 0; v < 256; v++) begin
      logic [7:0] vv;
      vv = 8'(v);
      if (vv == 8'h00) sb.push_back(mk(1, 0, 0));
      for (int b = 0; b < 8; b++) begin
        if (vv[b]) sb.push_back(mk(0, b, (vv >> (b + 1)) == 8'h00));
      end
      acc_or   = '0;
      acc_cnt  = 0;
      acc_zero = 0;
      send(vv);
      wait_idle();
      check("ex_or", 32'(acc_or), 32'(vv));
      check("ex_count", 32'(acc_cnt), 32'($countones(vv)));
      check("ex_zero", 32'(acc_zero), (vv == 8'h00) ? 32'd1 : 32'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
